// File: rtl/ara_xif_issue_ctrl_pkg.sv
// Shared types for the XIF issue controller: entry state and queue entry layout.
package ara_pkg;

    localparam int unsigned XifIdWidth = 4;
    localparam int unsigned XifXlen    = 64;

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        SPEC      = 2'd1,
        COMMITTED = 2'd2,
        KILLED    = 2'd3
    } xif_entry_state_e;

    typedef struct packed {
        logic [31:0]                 instr;
        logic [XifIdWidth-1:0]       id;
        logic [1:0][XifXlen-1:0]     rs;
        xif_entry_state_e            state;
    } xif_entry_t;

endpackage

// File: rtl/ara_xif_issue_ctrl_if.sv
// Bundle of the XIF issue/commit signals, the predecoder link and the dispatcher
// hand-off. master = core/predecoder/dispatcher side, slave = issue controller.
interface ara_xif_issue_ctrl_if #(
    parameter int unsigned IdWidth = 4,
    parameter int unsigned XLEN    = 64
) ();
    logic                    issue_valid_i;
    logic                    issue_ready_o;
    logic [31:0]             issue_instr_i;
    logic [IdWidth-1:0]      issue_id_i;
    logic [1:0][XLEN-1:0]    issue_rs_i;
    logic [1:0]              issue_rs_valid_i;
    logic                    issue_accept_o;
    logic                    issue_writeback_o;

    logic [31:0]             dec_instr_o;
    logic                    dec_accept_i;
    logic                    dec_writeback_i;
    logic [1:0]              dec_rs_read_i;

    logic                    commit_valid_i;
    logic [IdWidth-1:0]      commit_id_i;
    logic                    commit_kill_i;

    logic                    acc_valid_o;
    logic                    acc_ready_i;
    logic [31:0]             acc_instr_o;
    logic [IdWidth-1:0]      acc_id_o;
    logic [1:0][XLEN-1:0]    acc_rs_o;

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o,
        input  dec_instr_o,
        output dec_accept_i, dec_writeback_i, dec_rs_read_i,
        output commit_valid_i, commit_id_i, commit_kill_i,
        input  acc_valid_o, acc_instr_o, acc_id_o, acc_rs_o,
        output acc_ready_i
    );

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o,
        output dec_instr_o,
        input  dec_accept_i, dec_writeback_i, dec_rs_read_i,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        output acc_valid_o, acc_instr_o, acc_id_o, acc_rs_o,
        input  acc_ready_i
    );
endinterface

// File: rtl/ara_xif_issue_ctrl_id_cam.sv
// Id CAM: one-hot match of an id against the entries selected by valid_i.
module ara_xif_id_cam #(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = 4
) (
    input  logic [IdWidth-1:0]            id_i,
    input  logic [Depth-1:0][IdWidth-1:0] ids_i,
    input  logic [Depth-1:0]              valid_i,
    output logic [Depth-1:0]              match_o
);

    // Parallel compare of the searched id against every qualified entry.
    always_comb begin
        match_o = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            match_o[i] = valid_i[i] && (ids_i[i] == id_i);
        end
    end

endmodule

// File: rtl/ara_xif_issue_ctrl.sv
// XIF issue controller: completes the issue handshake with the predecoder's verdict,
// holds accepted instructions speculatively in order, and hands committed ones to
// the dispatcher one per cycle. Entry field widths follow ara_pkg, so IdWidth and
// XLEN must match XifIdWidth and XifXlen.
module ara_xif_issue_ctrl
    import ara_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = XifIdWidth,
    parameter int unsigned XLEN    = XifXlen
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ara_xif_issue_ctrl_if.slave  xif,
    output logic                 busy_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    xif_entry_t                     entries_q [Depth];
    logic [PtrW-1:0]                head_q, tail_q;
    logic [CntW-1:0]                count_q;

    logic [Depth-1:0][IdWidth-1:0]  ids;
    logic [Depth-1:0]               busy_mask, spec_mask;
    logic [Depth-1:0]               hit_match, commit_match;
    logic                           full, id_hit, ops_ok, enq, pop;
    xif_entry_state_e               head_state, enq_state;

    // Entry views feeding the two CAM searches.
    always_comb begin
        ids       = '0;
        busy_mask = '0;
        spec_mask = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            ids[i]       = entries_q[i].id;
            busy_mask[i] = entries_q[i].state != FREE;
            spec_mask[i] = entries_q[i].state == SPEC;
        end
    end

    ara_xif_id_cam #(.Depth(Depth), .IdWidth(IdWidth)) u_hit_cam (
        .id_i    (xif.issue_id_i),
        .ids_i   (ids),
        .valid_i (busy_mask),
        .match_o (hit_match)
    );

    ara_xif_id_cam #(.Depth(Depth), .IdWidth(IdWidth)) u_commit_cam (
        .id_i    (xif.commit_id_i),
        .ids_i   (ids),
        .valid_i (spec_mask),
        .match_o (commit_match)
    );

    assign full   = (count_q == CntW'(Depth));
    assign id_hit = |hit_match;
    assign ops_ok = &(xif.issue_rs_valid_i | ~xif.dec_rs_read_i);
    assign enq    = xif.issue_valid_i & xif.dec_accept_i & ~full & ~id_hit & ops_ok;

    assign xif.issue_ready_o     = xif.issue_valid_i & (~xif.dec_accept_i | (~full & ~id_hit & ops_ok));
    assign xif.issue_accept_o    = xif.dec_accept_i;
    assign xif.issue_writeback_o = xif.dec_writeback_i;
    assign xif.dec_instr_o       = xif.issue_instr_i;

    assign head_state = entries_q[head_q].state;
    assign pop        = ((head_state == COMMITTED) & xif.acc_ready_i) | (head_state == KILLED);

    assign xif.acc_valid_o = (head_state == COMMITTED);
    assign xif.acc_instr_o = entries_q[head_q].instr;
    assign xif.acc_id_o    = entries_q[head_q].id;
    assign xif.acc_rs_o    = entries_q[head_q].rs;
    assign busy_o          = (count_q != '0);

    // A commit aimed at the id being enqueued this cycle lands directly in the new entry.
    always_comb begin
        enq_state = SPEC;
        if (xif.commit_valid_i && (xif.commit_id_i == xif.issue_id_i)) begin
            enq_state = xif.commit_kill_i ? KILLED : COMMITTED;
        end
    end

    // Per-entry state machines plus head/tail/count bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                unique case (entries_q[i].state)
                    FREE: begin
                        if (enq && (PtrW'(i) == tail_q)) begin
                            entries_q[i] <= '{instr: xif.issue_instr_i,
                                              id:    xif.issue_id_i,
                                              rs:    xif.issue_rs_i,
                                              state: enq_state};
                        end
                    end
                    SPEC: begin
                        if (xif.commit_valid_i && commit_match[i]) begin
                            entries_q[i].state <= xif.commit_kill_i ? KILLED : COMMITTED;
                        end
                    end
                    COMMITTED, KILLED: begin
                        if (pop && (PtrW'(i) == head_q)) begin
                            entries_q[i].state <= FREE;
                        end
                    end
                    default: entries_q[i].state <= FREE;
                endcase
            end
            if (enq) tail_q <= tail_q + PtrW'(1);
            if (pop) head_q <= head_q + PtrW'(1);
            count_q <= count_q + CntW'(enq) - CntW'(pop);
        end
    end

endmodule

// File: tb/tb_ara_xif_issue_ctrl.sv
// Bench for ara_xif_issue_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against an in-order queue model.
module tb_ara_xif_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int M_SPEC = 1, M_COMMIT = 2, M_KILL = 3;

    typedef struct {
        logic [31:0]  instr;
        logic [3:0]   id;
        logic [127:0] rs;
        int           st;
    } m_ent_t;

    logic clk = 0;
    logic rst;
    logic busy;
    always #5 clk = ~clk;

    ara_xif_issue_ctrl_if #(.IdWidth(4), .XLEN(64)) xif ();

    ara_xif_issue_ctrl #(.Depth(DEPTH), .IdWidth(4), .XLEN(64)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .xif    (xif),
        .busy_o (busy)
    );

    m_ent_t mq[$];
    int errors = 0;
    int checks = 0;

    // DUT values captured during the last step, for literal checks.
    logic         s_ready, s_accept;
    logic         a_valid, a_busy;
    logic [3:0]   a_id;
    logic [31:0]  a_instr;
    logic [127:0] a_rs;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic bit m_hit(logic [3:0] id);
        foreach (mq[k]) if (mq[k].id == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        xif.issue_valid_i    = 0;
        xif.issue_instr_i    = '0;
        xif.issue_id_i       = '0;
        xif.issue_rs_i       = '0;
        xif.issue_rs_valid_i = '0;
        xif.dec_accept_i     = 0;
        xif.dec_writeback_i  = 0;
        xif.dec_rs_read_i    = '0;
        xif.commit_valid_i   = 0;
        xif.commit_id_i      = '0;
        xif.commit_kill_i    = 0;
        xif.acc_ready_i      = 0;
    endtask

    task automatic set_issue(input logic [3:0] id, input logic acc, input logic [1:0] rd,
                             input logic [1:0] rv, input logic [127:0] rs);
        xif.issue_valid_i    = 1;
        xif.issue_id_i       = id;
        xif.issue_instr_i    = $urandom;
        xif.issue_rs_i       = rs;
        xif.issue_rs_valid_i = rv;
        xif.dec_accept_i     = acc;
        xif.dec_writeback_i  = $urandom_range(0, 1);
        xif.dec_rs_read_i    = rd;
    endtask

    task automatic set_commit(input logic [3:0] id, input logic kill);
        xif.commit_valid_i = 1;
        xif.commit_id_i    = id;
        xif.commit_kill_i  = kill;
    endtask

    // One clock: check combinational response, advance model at the edge, check queue outputs.
    task automatic step();
        bit ops_ok, e_enq, e_rdy, pop, e_valid;
        m_ent_t ne;
        #1;
        ops_ok = ((xif.issue_rs_valid_i | ~xif.dec_rs_read_i) == 2'b11);
        e_enq  = xif.issue_valid_i && xif.dec_accept_i && (mq.size() < DEPTH)
                 && !m_hit(xif.issue_id_i) && ops_ok;
        e_rdy  = xif.issue_valid_i && (!xif.dec_accept_i || e_enq);
        s_ready  = xif.issue_ready_o;
        s_accept = xif.issue_accept_o;
        check("issue_ready", xif.issue_ready_o, e_rdy);
        if (e_rdy) begin
            check("issue_accept", xif.issue_accept_o, xif.dec_accept_i);
            check("issue_writeback", xif.issue_writeback_o, xif.dec_writeback_i);
        end
        check("dec_instr", xif.dec_instr_o, xif.issue_instr_i);
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            pop = (mq.size() > 0) &&
                  ((mq[0].st == M_COMMIT && xif.acc_ready_i) || mq[0].st == M_KILL);
            if (xif.commit_valid_i)
                foreach (mq[k])
                    if (mq[k].st == M_SPEC && mq[k].id == xif.commit_id_i)
                        mq[k].st = xif.commit_kill_i ? M_KILL : M_COMMIT;
            if (pop) void'(mq.pop_front());
            if (e_enq) begin
                ne.instr = xif.issue_instr_i;
                ne.id    = xif.issue_id_i;
                ne.rs    = xif.issue_rs_i;
                ne.st    = (xif.commit_valid_i && xif.commit_id_i == xif.issue_id_i)
                           ? (xif.commit_kill_i ? M_KILL : M_COMMIT) : M_SPEC;
                mq.push_back(ne);
            end
        end
        #1;
        a_valid = xif.acc_valid_o;
        a_busy  = busy;
        a_id    = xif.acc_id_o;
        a_instr = xif.acc_instr_o;
        a_rs    = xif.acc_rs_o;
        e_valid = (mq.size() > 0) && (mq[0].st == M_COMMIT);
        check("acc_valid", a_valid, e_valid);
        check("busy", a_busy, mq.size() > 0);
        if (e_valid) begin
            check("acc_id", a_id, mq[0].id);
            check("acc_instr", a_instr, mq[0].instr);
            check("acc_rs", a_rs, mq[0].rs);
        end
        @(negedge clk);
    endtask

    localparam logic [127:0] R3 = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;

    initial begin
        logic [3:0] spec_ids[$];
        rst = 1;
        idle();
        @(negedge clk);
        step();
        step();
        check("reset_valid", a_valid, 0);
        check("reset_busy", a_busy, 0);
        check("reset_id", a_id, 0);
        check("reset_instr", a_instr, 0);
        check("reset_rs", a_rs, 0);
        rst = 0;

        // Rejected issue completes at once and does not enqueue.
        set_issue(4'd7, 0, 2'b11, 2'b11, '0);
        step();
        check("rej_ready", s_ready, 1);
        check("rej_accept", s_accept, 0);
        check("rej_busy", a_busy, 0);

        // Accept id 3, commit two cycles later, dispatch.
        set_issue(4'd3, 1, 2'b11, 2'b11, R3);
        step();
        idle(); step();
        set_commit(4'd3, 0); step();
        check("commit_valid", a_valid, 1);
        check("commit_id", a_id, 3);
        check("commit_rs", a_rs, R3);
        idle(); xif.acc_ready_i = 1; step();
        check("dispatched_valid", a_valid, 0);

        // Kill ordering: killed head dropped in one cycle, id 2 next.
        set_issue(4'd1, 1, 2'b11, 2'b11, 128'h1); step();
        set_issue(4'd2, 1, 2'b11, 2'b11, 128'h2); step();
        idle(); set_commit(4'd1, 1); step();
        check("killed_head_valid", a_valid, 0);
        check("killed_head_busy", a_busy, 1);
        idle(); set_commit(4'd2, 0); step();
        check("after_drop_valid", a_valid, 1);
        check("after_drop_id", a_id, 2);
        idle(); xif.acc_ready_i = 1; step();
        check("kill_seq_busy", a_busy, 0);

        // Full queue back-pressure.
        for (int i = 8; i < 12; i++) begin
            set_issue(4'(i), 1, 2'b11, 2'b11, 128'(i)); step();
        end
        set_issue(4'd12, 1, 2'b11, 2'b11, '0); step();
        check("full_ready", s_ready, 0);
        set_issue(4'd8, 1, 2'b11, 2'b11, '0); step();
        check("dup_ready", s_ready, 0);
        set_issue(4'd13, 0, 2'b11, 2'b11, '0); step();
        check("full_rej_ready", s_ready, 1);
        for (int i = 8; i < 12; i++) begin
            idle(); set_commit(4'(i), 0); xif.acc_ready_i = 1; step();
        end
        for (int i = 0; i < 4; i++) begin
            idle(); xif.acc_ready_i = 1; step();
        end
        check("drain_busy", a_busy, 0);

        // Operand gating.
        set_issue(4'd4, 1, 2'b01, 2'b00, '0); step();
        check("ops_missing_ready", s_ready, 0);
        set_issue(4'd4, 1, 2'b01, 2'b01, '0); step();
        check("ops_ok_ready", s_ready, 1);
        idle(); set_commit(4'd4, 1); step();
        idle(); step();
        check("ops_drop_busy", a_busy, 0);

        // Commit in the same cycle as enqueue.
        set_issue(4'd5, 1, 2'b11, 2'b11, 128'h5); set_commit(4'd5, 0); step();
        check("same_cycle_valid", a_valid, 1);
        check("same_cycle_id", a_id, 5);
        idle(); xif.acc_ready_i = 1; step();

        // Reset with entries held.
        set_issue(4'd1, 1, 2'b11, 2'b11, 128'h1); step();
        set_issue(4'd2, 1, 2'b11, 2'b11, 128'h2); step();
        set_issue(4'd6, 1, 2'b11, 2'b11, 128'h6); set_commit(4'd1, 0); step();
        idle(); rst = 1; step();
        check("mid_reset_busy", a_busy, 0);
        check("mid_reset_valid", a_valid, 0);
        rst = 0;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) < 7) begin
                set_issue(4'($urandom_range(0, 7)), ($urandom_range(0, 9) < 8),
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3)),
                          {$urandom, $urandom, $urandom, $urandom});
            end
            if ($urandom_range(0, 9) < 4) begin
                spec_ids.delete();
                foreach (mq[k]) if (mq[k].st == M_SPEC) spec_ids.push_back(mq[k].id);
                if (spec_ids.size() > 0 && $urandom_range(0, 9) < 8)
                    set_commit(spec_ids[$urandom_range(0, spec_ids.size() - 1)],
                               ($urandom_range(0, 9) < 3));
                else
                    set_commit(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3));
            end
            xif.acc_ready_i = ($urandom_range(0, 9) < 7);
            step();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
